seq_detector_prog: RTL
======================

# seq_detector_prog

Parametrised, runtime-programmable serial bit-pattern detector. It is the general successor to the fixed 4-bit Mealy detectors in the assignment set. It watches a qualified serial bit stream for a pattern of up to MAX_LEN bits, supports overlapping and non-overlapping modes, and emits a registered one-cycle match pulse plus a saturating match count. Reset configuration detects 1101 with overlap, so it drops in where a fixed 1101 detector was used.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits; legal range is 2 to 32.
- CNT_W, default 8: width of the match counter.
- RST_PAT, default 8'b0000_1101: pattern loaded at reset, right-aligned.
- RST_LEN, default 4: pattern length loaded at reset.
- LEN_W, derived as $clog2(MAX_LEN+1): width of the length fields.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din_valid  in  1  qualifies din; when low, the detector holds all state.
- din  in  1  serial data bit. Pattern bits arrive MSB first: cfg_pattern[len-1] is the first bit.
- cfg_load  in  1  single-cycle strobe that loads cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bits at and above len are ignored.
- cfg_len  in  LEN_W  pattern length; legal range is 1 to MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- cnt_clr  in  1  synchronous clear of match_count.
- match  out  1  registered one-cycle pulse.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  one-cycle pulse on a rejected load.
- armed  out  1  high when enough history exists for a match on the next valid bit.

## Operation
- Registers:
  - hist: MAX_LEN-bit shift register.
  - fill: fill counter, 0 to MAX_LEN.
  - Active configuration: pat, len, ovl.
  - match, match_count.
- FSM states:
  - FILL: fill < len-1.
  - RUN: fill >= len-1, so armed = 1.
- On a valid bit:
  - hist becomes {hist[MAX_LEN-2:0], din}.
  - fill increments and saturates at MAX_LEN.
  - FILL transitions to RUN when fill reaches len-1.
- Match condition: state is RUN and {hist[len-2:0], din} == pat[len-1:0]. For len = 1 the comparison reduces to din == pat[0], and the block is always in RUN.
- On a match:
  - match is 1 on the next cycle.
  - match_count increments unless it is all ones; it saturates at all ones.
  - If ovl = 0: fill is cleared to 0, the state returns to FILL (RUN if len = 1), and hist is cleared.
  - If ovl = 1: fill is kept and the state stays RUN.
- When din_valid = 0:
  - hist, fill and the state are unchanged.
  - match is 0 on the next cycle.
- cfg_load with 1 <= cfg_len <= MAX_LEN:
  - Latch the new configuration.
  - Clear hist and fill.
  - Go to FILL, or RUN if cfg_len = 1.
  - match_count is not affected.
- cfg_load with cfg_len = 0 or cfg_len > MAX_LEN:
  - The configuration and history are unchanged.
  - cfg_err pulses high for one cycle.
- cfg_load and din_valid in the same cycle: the load has priority and that din is discarded, with no shift and no match.
- cnt_clr and a match in the same cycle: the clear wins and match_count becomes 0. The match pulse still asserts.
- Reset values:
  - Outputs: match = 0, match_count = 0, cfg_err = 0, armed = 0 (RST_LEN >= 2).
  - Internal state: hist = 0, fill = 0, pat = RST_PAT, len = RST_LEN, ovl = 1, state FILL.

## Timing
- Latency: the bit sampled at edge k produces match high from edge k to edge k+1. This is one-cycle registered Mealy behaviour.
- match_count updates on the same edge that match rises. cfg_err rises on the edge that samples cfg_load.
- Non-overlap mode: after a match, the next possible match is at least len valid bits later. Overlap mode: the next match can come on the very next valid bit, provided the pattern allows it (for example all-ones).
- Reset mid-stream: partial history is discarded immediately, and the active configuration returns to the reset values.
- Throughput: one bit per cycle, with no stall outputs.

## Structure
- Package seq_det_pkg contains:
  - State enum {FILL, RUN}.
  - Default constants DEF_PAT = 4'b1101, DEF_LEN = 4, DEF_OVL = 1.
  - A length-validity check function.
- Sub-module sat_counter (parameter W, ports inc and clr, clear has priority) implements match_count. It is reusable by later statistics blocks.

## Test plan
- Reset defaults, stream 1,1,0,1,1,0,1 all valid → match pulses on the cycles after bit 4 and bit 7; match_count = 2.
- Load pattern 3'b101, len 3, overlap 0; stream 1,0,1,0,1 → one match, after bit 3; count = 1. Repeat with overlap 1 → two matches, after bits 3 and 5.
- din_valid low for 3 cycles between bits 1,1,0 and 1 of 1101 → match still fires after the final valid bit; match = 0 during the gaps.
- Load with cfg_len = 0, then cfg_len = MAX_LEN+1 → cfg_err pulses twice; the reset pattern 1101 still detects.
- Pattern 1, len 1, overlap 1, CNT_W = 2; stream 1,1,1,1,1 → match high for 5 cycles; count saturates at 3. cnt_clr coincident with a match → count = 0.
- Assert rst after 1,1,0 of 1101, release it, then send 1 → no match; armed = 0 after reset.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

    // FILL: not enough history yet for a match; RUN: next valid bit can match.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } det_state_e;

    // Power-on configuration: a drop-in replacement for the fixed 1101 detector.
    localparam logic [3:0] DEF_PAT = 4'b1101;
    localparam int         DEF_LEN = 4;
    localparam logic       DEF_OVL = 1'b1;

    // A programmed length is usable when it lies in 1..max_len.
    function automatic logic len_is_valid(input int unsigned len,
                                          input int unsigned max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up on inc, hold at all ones, clear has priority over inc.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; = here would create ordering-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector. Bits arrive MSB first;
// a hit on the sampled bit raises match on the following cycle.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DEF_PAT),
    parameter int                 RST_LEN = DEF_LEN,
    parameter int                 LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    // History plus the incoming bit, one wider than the pattern.
    localparam int HW = MAX_LEN + 1;

    det_state_e         state, state_next;
    logic [MAX_LEN-1:0] hist, hist_next;
    logic [LEN_W-1:0]   fill, fill_next, fill_sat;
    logic [MAX_LEN-1:0] pat, pat_next;
    logic [LEN_W-1:0]   len, len_next;
    logic               ovl, ovl_next;

    logic [HW-1:0]      cmp_mask;
    logic [HW-1:0]      cmp_diff;
    logic               pattern_eq;
    logic               load_ok;
    logic               hit;

    // Compare the newest len bits of {hist, din} against the active pattern.
    always_comb begin
        cmp_mask   = (HW'(1) << len) - HW'(1);
        cmp_diff   = ({hist, din} ^ {1'b0, pat}) & cmp_mask;
        pattern_eq = (cmp_diff == '0);
        load_ok    = len_is_valid(32'(cfg_len), MAX_LEN);
        fill_sat   = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath update: a load beats a data bit in the same cycle.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        hist_next  = hist;
        fill_next  = fill;
        pat_next   = pat;
        len_next   = len;
        ovl_next   = ovl;
        if (cfg_load) begin
            if (load_ok) begin
                pat_next   = cfg_pattern;
                len_next   = cfg_len;
                ovl_next   = cfg_overlap;
                hist_next  = '0;
                fill_next  = '0;
                state_next = (cfg_len == LEN_W'(1)) ? RUN : FILL;
            end
        end else if (din_valid) begin
            if (hit && !ovl) begin
                // Non-overlapping: restart from an empty history.
                hist_next  = '0;
                fill_next  = '0;
                state_next = (len == LEN_W'(1)) ? RUN : FILL;
            end else begin
                hist_next = {hist[MAX_LEN-2:0], din};
                fill_next = fill_sat;
                if (fill_sat >= len - LEN_W'(1)) begin
                    state_next = RUN;
                end
            end
        end
    end

    // Outputs decoded from the current state and inputs.
    always_comb begin
        armed = (state == RUN);
        hit   = din_valid && !cfg_load && (state == RUN) && pattern_eq;
    end

    // History, fill level, active configuration and the registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            pat     <= RST_PAT;
            len     <= LEN_W'(RST_LEN);
            ovl     <= DEF_OVL;
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            hist    <= hist_next;
            fill    <= fill_next;
            pat     <= pat_next;
            len     <= len_next;
            ovl     <= ovl_next;
            match   <= hit;
            cfg_err <= cfg_load && !load_ok;
        end
    end

    // Match counter moves on the same edge that match rises.
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .clr   (cnt_clr),
        .count (match_count)
    );

endmodule
